// File: rtl/shift_register_pkg.sv
// Shared constants for the universal shift register: mode/direction encodings and default width.
package shift_register_pkg;

  localparam logic MODE_PISO = 1'b0;
  localparam logic MODE_SIPO = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/shift_register_cnt.sv
// Saturating accepted-shift counter with a registered pulse when it first reaches WIDTH.
// Instantiated by shift_register only when SHIFT_DONE_EN is defined.
module shift_register_cnt
  import shift_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        count_q <= '0;
      end else if (inc && (count_q != CNT_MAX)) begin
        count_q <= count_q + CW'(1);
        // Pulse only on the transition into WIDTH; saturation keeps it quiet afterwards.
        done    <= (count_q == (CNT_MAX - CW'(1)));
      end
    end
  end

endmodule

// File: rtl/shift_register.sv
// Dual-mode (PISO/SIPO) universal shift register with per-cycle direction select.
// Optional shft_done output and shift counter are enabled by defining SHIFT_DONE_EN.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             shft_en,
  input  logic             mode,
  input  logic             dir,
  input  logic             se_in,
  input  logic [WIDTH-1:0] pa_in,
  output logic [WIDTH-1:0] shft_reg,
  output logic [WIDTH-1:0] pa_out,
  output logic             se_out
`ifdef SHIFT_DONE_EN
  ,
  output logic             shft_done
`endif
);

  // Controls are level-sampled on each rising edge (ld over shft_en over hold);
  // there is no valid/ready handshake, so every edge acts on the current inputs.
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shifted;
  logic             fill;

  always_comb begin
    fill = 1'b0;
    case (mode)
      MODE_PISO: fill = 1'b0;
      MODE_SIPO: fill = se_in;
    endcase
  end

  always_comb begin
    shifted = data_q;
    case (dir)
      DIR_RIGHT: shifted = {fill, data_q[WIDTH-1:1]};
      DIR_LEFT:  shifted = {data_q[WIDTH-2:0], fill};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (ld) begin
      data_q <= pa_in;
    end else if (shft_en) begin
      data_q <= shifted;
    end
  end

  assign shft_reg = data_q;
  assign pa_out   = data_q;
  // Serial output is the bit that would leave on the next shift in the current direction.
  assign se_out   = (dir == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];

`ifdef SHIFT_DONE_EN
  shift_register_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (ld),
    .inc  (shft_en & ~ld),
    .done (shft_done)
  );
`endif

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register: directed sequences plus randomized traffic
// compared against an arithmetic reference model (SHIFT_DONE_EN checked when defined).
module tb_shift_register;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         ld;
  logic         shft_en;
  logic         mode;
  logic         dir;
  logic         se_in;
  logic [W-1:0] pa_in;
  logic [W-1:0] shft_reg;
  logic [W-1:0] pa_out;
  logic         se_out;
`ifdef SHIFT_DONE_EN
  logic         shft_done;
`endif

  shift_register #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .shft_en  (shft_en),
    .mode     (mode),
    .dir      (dir),
    .se_in    (se_in),
    .pa_in    (pa_in),
    .shft_reg (shft_reg),
    .pa_out   (pa_out),
    .se_out   (se_out)
`ifdef SHIFT_DONE_EN
    ,
    .shft_done(shft_done)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned m_val;
  int unsigned m_cnt;
  int unsigned m_done;
  int          n_cmp;
  int          n_err;
  logic [W-1:0] exp_q[$];

  function automatic int unsigned model_shift(input int unsigned v, input logic d,
                                              input logic m, input logic s);
    int unsigned f;
    f = (m == 1'b1) ? int'(s) : 0;
    if (d == 1'b0) return (v / 2) + f * (1 << (W - 1));
    return ((v * 2) + f) % (1 << W);
  endfunction

  function automatic int unsigned model_se(input int unsigned v, input logic d);
    return (d == 1'b1) ? ((v >> (W - 1)) & 1) : (v & 1);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".reg"}, 32'(shft_reg), m_val);
    check({tag, ".pa"}, 32'(pa_out), m_val);
    check({tag, ".se"}, 32'(se_out), model_se(m_val, dir));
`ifdef SHIFT_DONE_EN
    check({tag, ".done"}, 32'(shft_done), m_done);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic l, input logic s, input logic m, input logic d,
                        input logic si, input logic [W-1:0] p);
    ld = l; shft_en = s; mode = m; dir = d; se_in = si; pa_in = p;
  endtask

  // Advance one edge; the model consumes the inputs present at that edge.
  task automatic tick();
    int unsigned nxt_val;
    int unsigned nxt_cnt;
    int unsigned nxt_done;
    nxt_val  = m_val;
    nxt_cnt  = m_cnt;
    nxt_done = 0;
    if (ld) begin
      nxt_val = int'(pa_in);
      nxt_cnt = 0;
    end else if (shft_en) begin
      nxt_val = model_shift(m_val, dir, mode, se_in);
      if (m_cnt < W) begin
        nxt_cnt  = m_cnt + 1;
        nxt_done = (nxt_cnt == W) ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_val  = nxt_val;
      m_cnt  = nxt_cnt;
      m_done = nxt_done;
    end
  endtask

  // Reset asserted between edges: outputs must clear without waiting for clk.
  task automatic async_reset(input string tag);
    #1 rst = 1'b0;
    #1;
    m_val = 0; m_cnt = 0; m_done = 0;
    check_outputs({tag, ".async"});
    #1 rst = 1'b1;
  endtask

  task automatic run_directed(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check({tag, ".const"}, 32'(shft_reg), 32'(e));
      check_outputs(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] bits;
    n_cmp = 0; n_err = 0;
    m_val = 0; m_cnt = 0; m_done = 0;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #12;
    check_outputs("reset");
    rst = 1'b1;

    // PISO right: load 1011 then 4 shifts right
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011);
    tick();
    check("piso_r.load", 32'(shft_reg), 32'hB);
    check("piso_r.se0", 32'(se_out), 32'd1);
    check_outputs("piso_r.load");
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    exp_q = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    run_directed("piso_r");

    // PISO left: load 1011 then 4 shifts left
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011);
    tick();
    check("piso_l.se0", 32'(se_out), 32'd1);
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    exp_q = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
    run_directed("piso_l");

    // SIPO left from reset: serial 1,1,0,1
    async_reset("sipo_l");
    bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b1, bits[i], '0);
      tick();
      check_outputs("sipo_l");
    end
    check("sipo_l.final", 32'(pa_out), 32'hD);

    // SIPO right from reset: serial 1,0,1,1
    async_reset("sipo_r");
    bits = 4'b1101;
    exp_q = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, bits[i], '0);
      tick();
      check("sipo_r.const", 32'(shft_reg), 32'(exp_q.pop_front()));
      check_outputs("sipo_r");
    end

    // Load wins over shift
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0110);
    tick();
    check("ld_prio", 32'(shft_reg), 32'h6);
    check_outputs("ld_prio");

    // Async reset mid-shift, plus combinational se_out follow of dir
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("mid.shift", 32'(shft_reg), 32'h5);
    dir = 1'b1;
    #1;
    check("dir_follow.left", 32'(se_out), 32'd0);
    dir = 1'b0;
    #1;
    check("dir_follow.right", 32'(se_out), 32'd1);
    async_reset("mid");
    check("mid.cleared", 32'(shft_reg), 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("mid.hold", 32'(shft_reg), 32'h0);
    check_outputs("mid.hold");

    // Shift-done pulse: load then 4 shifts, then extra shifts stay quiet
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001);
    tick();
    check_outputs("done.load");
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_outputs("done.shift");
`ifdef SHIFT_DONE_EN
      check("done.const", 32'(shft_done), (i == 3) ? 32'd1 : 32'd0);
`endif
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)));
      tick();
      check_outputs("rand");
      if ($urandom_range(0, 9) == 0) begin
        dir = ~dir;
        #1;
        check_outputs("rand.dir");
      end
      if ($urandom_range(0, 49) == 0) async_reset("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/shift_register.md
Name: shift_register

Overview:
Dual-mode universal shift register. Supports PISO (parallel load, serial out) and SIPO (serial in, parallel out).
- Shift direction is selectable per cycle.
- Used as a serializer/deserializer stage between parallel datapaths and single-bit links.
- Contents are visible every cycle on a parallel bus plus a serial output bit.

Parameters:
- WIDTH, 4, register width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ld  input  1  synchronous parallel load strobe.
- shft_en  input  1  shift enable.
- mode  input  1  0 = PISO, 1 = SIPO.
- dir  input  1  0 = shift right (toward bit 0), 1 = shift left (toward bit WIDTH-1).
- se_in  input  1  serial data in.
- pa_in  input  WIDTH  parallel load data.
- shft_reg  output  WIDTH  current register contents.
- pa_out  output  WIDTH  parallel output.
- se_out  output  1  serial output bit.

Behaviour:
- Reset: rst=0 clears the register to 0 immediately, independent of clk, and holds it while low. Consequently shft_reg=0, pa_out=0, se_out=0.
- Reset mid-operation: any in-progress serialization is discarded. The first edge after release behaves as from the cleared state.
- Priority on each rising edge with rst=1: ld, then shft_en, then hold.
- ld=1: reg <= pa_in in both modes. shft_en is ignored that cycle.
- shft_en=1, ld=0, shift right (dir=0): reg <= {fill, reg[WIDTH-1:1]}.
- shft_en=1, ld=0, shift left (dir=1): reg <= {reg[WIDTH-2:0], fill}.
- Fill bit: mode=1 (SIPO) uses se_in; mode=0 (PISO) uses 0.
- shft_reg is the register itself.
- pa_out equals the register contents combinationally, in both modes.
- se_out is combinational and shows the bit that leaves on the next right/left shift: dir=0 gives reg[0]; dir=1 gives reg[WIDTH-1].
- One-cycle latency from ld/shft_en to shft_reg. se_out updates in the same cycle as shft_reg and also follows dir changes immediately.
- mode and dir may change on any cycle; the new values take effect at the next edge. No other handshake.
- Shifting past WIDTH cycles in PISO keeps producing 0s; no wrap.

Optional Feature:
- Macro SHIFT_DONE_EN.
- Defined:
  - Adds output shft_done (1 bit) and an internal counter of $clog2(WIDTH+1) bits.
  - The counter clears on reset and on ld. It increments on each accepted shift and saturates at WIDTH.
  - shft_done is a registered one-cycle pulse on the cycle the counter reaches WIDTH.
- Undefined: no counter and no shft_done port. Behaviour is otherwise identical.

Decomposition:
- Package shift_register_pkg holds:
  - localparams MODE_PISO=1'b0, MODE_SIPO=1'b1, DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
  - Default WIDTH constant.
- One optional sub-module, shift_register_cnt, holds the saturating shift counter (used only under SHIFT_DONE_EN).
- The core datapath stays in the top module.

Test Plan:
- PISO right: rst low then released, mode=0, ld with pa_in=1011, then 4 shifts with dir=0.
  - shft_reg: 1011, 0101, 0010, 0001, 0000.
  - se_out before each shift: 1, 1, 0, 1.
- PISO left: load 1011, dir=1, 4 shifts.
  - shft_reg: 0110, 1100, 1000, 0000.
  - se_out initially 1, then 0, 1, 1.
- SIPO left after reset: mode=1, dir=1, shft_en=1, se_in sequence 1, 1, 0, 1.
  - shft_reg/pa_out: 0001, 0011, 0110, 1101.
- SIPO right: se_in sequence 1, 0, 1, 1 with dir=0.
  - shft_reg: 1000, 0100, 1010, 1101.
- Simultaneous ld and shft_en with pa_in=0110 → shft_reg=0110, no shift.
- Async reset mid-shift: after load 1011 and one shift, drive rst=0 between edges.
  - shft_reg=0000 immediately.
  - After release with no ld/shft_en, it stays 0000.
  - Under SHIFT_DONE_EN: load, then 4 shifts → shft_done high exactly one cycle after the 4th shift.
